// File: rtl/spi_slave_regs.sv
// rtl/spi_slave_regs.sv - SPI mode-0 slave exposing CTRL/STATUS registers to the I2C bridge
// Optional: SPI_SLAVE_REGS_MISO_TRISTATE_EN floats spi_miso while slave select is high.
`timescale 1ns/1ps

module spi_slave_regs (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        spi_ss,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic [4:0]  fsm_state,
  input  logic [1:0]  fsm_bit_state,
  output logic [15:0] ctrl_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [6:0] ADDR_CTRL   = 7'h00;
  localparam logic [6:0] ADDR_STATUS = 7'h01;

  // Synchronizers; the third SS/SCLK flop is the edge-detect history.
  logic ss_meta_q, ss_sync_q, ss_prev_q;
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ss_meta_q   <= 1'b1;
      ss_sync_q   <= 1'b1;
      ss_prev_q   <= 1'b1;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      ss_meta_q   <= spi_ss;
      ss_sync_q   <= ss_meta_q;
      ss_prev_q   <= ss_sync_q;
      sclk_meta_q <= spi_clk;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      mosi_meta_q <= spi_mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  logic ss_fall, ss_rise, sclk_rise, sclk_fall;
  assign ss_fall   =  ss_prev_q   & ~ss_sync_q;
  assign ss_rise   = ~ss_prev_q   &  ss_sync_q;
  assign sclk_rise = ~sclk_prev_q &  sclk_sync_q;
  assign sclk_fall =  sclk_prev_q & ~sclk_sync_q;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        data_idx_q, data_idx_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic        miso_q, miso_d;
  logic        ro_q, ro_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  stat_lo_q, stat_lo_d;
  logic [15:0] ctrl_q, ctrl_d;
  logic        init_done_q, init_done_d;

  logic [7:0] rx_byte;
  logic       byte_done;
  logic [7:0] marker;
  logic       writable;
  logic [7:0] first_data;
  logic [7:0] second_data;

  assign rx_byte   = {rx_q[6:0], mosi_sync_q};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
  assign marker    = init_done_q ? 8'h0F : 8'h00;
  assign writable  = !ro_q && (addr_q == ADDR_CTRL);

  // The command byte is still in flight here, so decode its address from rx_byte.
  always_comb begin
    first_data = 8'h00;
    if (rx_byte[6:0] == ADDR_CTRL) begin
      first_data = ctrl_q[15:8];
    end else if (rx_byte[6:0] == ADDR_STATUS) begin
      first_data = {3'b000, fsm_state};
    end
  end

  always_comb begin
    second_data = 8'h00;
    if (addr_q == ADDR_CTRL) begin
      second_data = ctrl_q[7:0];
    end else if (addr_q == ADDR_STATUS) begin
      second_data = stat_lo_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    data_idx_d  = data_idx_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    ro_d        = ro_q;
    addr_d      = addr_q;
    stat_lo_d   = stat_lo_q;
    ctrl_d      = ctrl_q;
    init_done_d = init_done_q;

    if (state_q == ST_IDLE) begin
      if (ss_fall) begin
        state_d    = ST_CMD;
        bit_cnt_d  = 3'd0;
        data_idx_d = 1'b0;
        rx_d       = 8'h00;
        miso_d     = marker[7];
        tx_d       = {marker[6:0], 1'b0};
      end
    end else begin
      if (sclk_rise) begin
        rx_d      = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (sclk_fall) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
      // Whole byte received: commit it and stage the next outgoing byte.
      if (byte_done) begin
        case (state_q)
          ST_CMD: begin
            ro_d       = rx_byte[7];
            addr_d     = rx_byte[6:0];
            stat_lo_d  = {6'b000000, fsm_bit_state};
            tx_d       = first_data;
            data_idx_d = 1'b0;
            state_d    = ST_DATA;
          end
          ST_DATA: begin
            if (writable) begin
              if (!data_idx_q) begin
                ctrl_d[15:8] = rx_byte;
              end else begin
                ctrl_d[7:0] = rx_byte;
              end
              init_done_d = 1'b1;
            end
            if (!data_idx_q) begin
              tx_d       = second_data;
              data_idx_d = 1'b1;
            end else begin
              tx_d    = 8'h00;
              state_d = ST_DRAIN;
            end
          end
          default: begin
            tx_d = 8'h00;
          end
        endcase
      end
      // Evaluated after the commit so a coincident final SCLK rise still lands.
      if (ss_rise) begin
        state_d = ST_IDLE;
        miso_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      data_idx_q  <= 1'b0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      miso_q      <= 1'b0;
      ro_q        <= 1'b1;
      addr_q      <= 7'h00;
      stat_lo_q   <= 8'h00;
      ctrl_q      <= 16'h0000;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      data_idx_q  <= data_idx_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      ro_q        <= ro_d;
      addr_q      <= addr_d;
      stat_lo_q   <= stat_lo_d;
      ctrl_q      <= ctrl_d;
      init_done_q <= init_done_d;
    end
  end

  assign ctrl_out = ctrl_q;

`ifdef SPI_SLAVE_REGS_MISO_TRISTATE_EN
  assign spi_miso = ss_sync_q ? 1'bz : miso_q;
`else
  assign spi_miso = ss_sync_q ? 1'b0 : miso_q;
`endif

endmodule

// File: tb/tb_spi_slave_regs.sv
// tb/tb_spi_slave_regs.sv - randomized scoreboard bench for spi_slave_regs
`timescale 1ns/1ps

module tb_spi_slave_regs;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        spi_ss = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [4:0]  fsm_st = 5'd0;
  logic [1:0]  fsm_bit = 2'd0;
  logic [15:0] ctrl_out;

  spi_slave_regs dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .spi_ss        (spi_ss),
    .spi_clk       (spi_clk),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .fsm_state     (fsm_st),
    .fsm_bit_state (fsm_bit),
    .ctrl_out      (ctrl_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  exp_miso[$];
  logic [15:0] exp_ctrl[$];

  // Reference register state
  logic [15:0] m_ctrl = 16'h0000;
  bit          m_init = 1'b0;

  logic [7:0] tx_b [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // MISO monitor: master samples on SCLK rise; a byte is checked once 8 bits arrive.
  initial begin
    int         cnt;
    logic [7:0] sh;
    cnt = 0;
    sh  = 8'h00;
    forever begin
      @(posedge spi_clk or negedge spi_ss);
      if (!spi_ss && spi_clk) begin
        sh = {sh[6:0], spi_miso};
        cnt++;
        if (cnt == 8) begin
          if (exp_miso.size() == 0) check("miso_unexpected_byte", {24'd0, sh}, 32'hFFFF_FFFF);
          else check("miso_byte", {24'd0, sh}, {24'd0, exp_miso.pop_front()});
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // CTRL monitor: register value checked a few clocks after each transaction ends.
  initial begin
    forever begin
      @(posedge spi_ss);
      repeat (8) @(negedge clk);
      if (exp_ctrl.size() != 0) check("ctrl_out", {16'd0, ctrl_out}, {16'd0, exp_ctrl.pop_front()});
    end
  end

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      spi_mosi = b[7-k];
      repeat (5) @(negedge clk);
      spi_clk = 1'b1;
      repeat (10) @(negedge clk);
      spi_clk = 1'b0;
      repeat (5) @(negedge clk);
    end
  endtask

  // n full bytes from tx_b, then 'part' bits of tx_b[n]; optional reset before SS rises.
  task automatic xfer(input int n, input int part, input bit do_rst);
    logic [6:0]  addr;
    bit          wr;
    logic [15:0] old;
    addr = tx_b[0][6:0];
    wr   = (tx_b[0][7] == 1'b0) && (addr == 7'h00);
    if (addr == 7'h00) old = m_ctrl;
    else if (addr == 7'h01) old = {3'b000, fsm_st, 6'b000000, fsm_bit};
    else old = 16'h0000;
    if (n >= 1) exp_miso.push_back(m_init ? 8'h0F : 8'h00);
    if (n >= 2) begin
      exp_miso.push_back(old[15:8]);
      if (wr) begin m_ctrl[15:8] = tx_b[1]; m_init = 1'b1; end
    end
    if (n >= 3) begin
      exp_miso.push_back(old[7:0]);
      if (wr) begin m_ctrl[7:0] = tx_b[2]; m_init = 1'b1; end
    end
    for (int i = 3; i < n; i++) exp_miso.push_back(8'h00);
    if (do_rst) begin m_ctrl = 16'h0000; m_init = 1'b0; end
    exp_ctrl.push_back(m_ctrl);

    @(negedge clk);
    spi_ss = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < n; i++) send_bits(tx_b[i], 8);
    if (part > 0) send_bits(tx_b[n], part);
    if (do_rst) begin
      aresetn = 1'b0;
      #1;
      check("midreset_ctrl", {16'd0, ctrl_out}, 32'd0);
      check("midreset_miso", {31'd0, spi_miso}, 32'd0);
      repeat (3) @(negedge clk);
      aresetn = 1'b1;
    end
    repeat (10) @(negedge clk);
    spi_ss = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic set3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    tx_b[0] = a; tx_b[1] = b; tx_b[2] = c;
    for (int i = 3; i < 8; i++) tx_b[i] = 8'h00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] addrs [5];
    addrs[0] = 7'h00; addrs[1] = 7'h00; addrs[2] = 7'h01; addrs[3] = 7'h02; addrs[4] = 7'h7F;

    repeat (4) @(negedge clk);
    check("reset_ctrl", {16'd0, ctrl_out}, 32'd0);
    check("reset_miso", {31'd0, spi_miso}, 32'd0);
    aresetn = 1'b1;
    repeat (10) @(negedge clk);

    set3(8'h00, 8'hFF, 8'h00); xfer(3, 0, 1'b0);
    set3(8'h00, 8'h00, 8'hFF); xfer(3, 0, 1'b0);
    set3(8'h00, 8'h00, 8'hFF); xfer(3, 0, 1'b0);
    fsm_st = 5'b00100; fsm_bit = 2'b10;
    set3(8'h81, 8'hAA, 8'h55); xfer(3, 0, 1'b0);
    set3(8'h80, 8'h12, 8'h34); xfer(3, 0, 1'b0);
    set3(8'h00, 8'hAB, 8'hCD); xfer(1, 4, 1'b0);
    set3(8'h80, 8'h00, 8'h00); xfer(3, 0, 1'b0);
    set3(8'h02, 8'h11, 8'h22); xfer(5, 0, 1'b0);

    for (int t = 0; t < 26; t++) begin
      int n, part;
      fsm_st  = 5'($urandom);
      fsm_bit = 2'($urandom);
      for (int i = 0; i < 8; i++) tx_b[i] = 8'($urandom);
      tx_b[0] = {1'($urandom_range(0, 1)), addrs[$urandom_range(0, 4)]};
      n    = $urandom_range(1, 4);
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      xfer(n, part, 1'b0);
    end

    set3(8'h00, 8'h5A, 8'hA5); xfer(1, 3, 1'b1);
    set3(8'h00, 8'h12, 8'h34); xfer(3, 0, 1'b0);
    set3(8'h80, 8'h00, 8'h00); xfer(3, 0, 1'b0);

    repeat (20) @(negedge clk);
    check("miso_queue_drained", 32'(exp_miso.size()), 32'd0);
    check("ctrl_queue_drained", 32'(exp_ctrl.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
